// File: rtl/dispatcher_4bits_pkg.sv
// dispatcher_pkg: constants shared by the dispatcher top, its FIFO and its
// handshake interface.
//   DATA_W            width of a dispatched word
//   DEST_OUT0/OUT1    destination codes carried with each word
//   ENTRY_W           width of one buffered entry {dest, data}
//   DEST_BIT          bit position of dest inside an entry
//   make_entry()      packs dest and data into the entry layout
package dispatcher_pkg;

  localparam int DATA_W   = 4;
  localparam int ENTRY_W  = DATA_W + 1;
  localparam int DEST_BIT = DATA_W;

  localparam logic DEST_OUT0 = 1'b0;
  localparam logic DEST_OUT1 = 1'b1;

  function automatic logic [ENTRY_W-1:0] make_entry(input logic dest,
                                                    input logic [DATA_W-1:0] data);
    logic [ENTRY_W-1:0] e;
    e                = '0;
    e[DEST_BIT]      = dest;
    e[DATA_W-1:0]    = data;
    return e;
  endfunction

endpackage

// File: rtl/dispatcher_4bits_if.sv
// dispatcher_4bits_if: groups the upstream valid/ready stream and the
// demux-facing signals (word, select, valid, per-destination acks).
//   slave  : the dispatcher side (consumes the stream, drives the demux)
//   master : the environment side (produces the stream, acks the words)
interface dispatcher_4bits_if;
  import dispatcher_pkg::*;

  logic [DATA_W-1:0] in_data;
  logic              in_dest;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] dmx_data;
  logic              dmx_sel;
  logic              dmx_valid;
  logic              ack0;
  logic              ack1;

  modport slave (
    input  in_data, in_dest, in_valid, ack0, ack1,
    output in_ready, dmx_data, dmx_sel, dmx_valid
  );

  modport master (
    output in_data, in_dest, in_valid, ack0, ack1,
    input  in_ready, dmx_data, dmx_sel, dmx_valid
  );

endinterface

// File: rtl/dispatcher_4bits_fifo.sv
// fifo_sync_ft: synchronous first-word-fall-through FIFO.
//   clk, rst : clock and synchronous active-high reset (pointers/level only)
//   push     : write wdata this cycle (ignored when full)
//   wdata    : entry to store
//   pop      : retire the head entry this cycle (ignored when empty)
//   rdata    : head entry, valid whenever empty=0
//   level    : occupancy, 0..DEPTH
//   full     : level == DEPTH
//   empty    : level == 0
// DEPTH must be a power of two >= 2 so the pointers wrap naturally.
module fifo_sync_ft #(
  parameter int WIDTH = 5,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [WIDTH-1:0]       wdata,
  input  logic                   pop,
  output logic [WIDTH-1:0]       rdata,
  output logic [$clog2(DEPTH):0] level,
  output logic                   full,
  output logic                   empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem_reg [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [LW-1:0]    level_reg;
  logic [LW-1:0]    level_next;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (level_reg == LW'(DEPTH));
  assign empty   = (level_reg == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  // Head is read combinationally so a word written at edge N is visible
  // right after that edge; the array is tiny, so this maps to LUT RAM.
  assign rdata = mem_reg[rd_ptr_reg];
  assign level = level_reg;

  always_comb begin
    level_next = level_reg;
    case ({push_ok, pop_ok})
      2'b10:   level_next = level_reg + LW'(1);
      2'b01:   level_next = level_reg - LW'(1);
      default: level_next = level_reg;
    endcase
  end

  // Storage has no reset: reset empties the FIFO through the pointers.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_reg[wr_ptr_reg] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      level_reg <= level_next;
    end
  end

endmodule

// File: rtl/dispatcher_4bits.sv
// dispatcher_4bits: buffers 4-bit words from a valid/ready stream and presents
// them, with a destination select, to a 1-to-2 demux. A word retires only when
// the consumer it addresses acks it.
//   clk, rst  : clock, synchronous active-high reset
//   bus       : stream in (in_data/in_dest/in_valid/in_ready) and demux side
//               (dmx_data/dmx_sel/dmx_valid, ack0/ack1)
//   rr_en     : 1 = destinations assigned by an alternating pointer
//   level     : FIFO occupancy
//   cnt0/cnt1 : wrapping counts of words delivered to out0/out1
module dispatcher_4bits
  import dispatcher_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  dispatcher_4bits_if.slave      bus,
  input  logic                   rr_en,
  output logic [$clog2(DEPTH):0] level,
  output logic [CNT_W-1:0]       cnt0,
  output logic [CNT_W-1:0]       cnt1
);

  logic               rr_ptr_reg;
  logic               push;
  logic               pop;
  logic               push_dest;
  logic [ENTRY_W-1:0] head;
  logic               fifo_full;
  logic               fifo_empty;
  logic               head_sel;
  logic [1:0]         deliver;

  // in_ready comes from registered occupancy only, so no ack->ready path.
  assign bus.in_ready = !fifo_full;
  assign push         = bus.in_valid && !fifo_full;
  assign push_dest    = rr_en ? rr_ptr_reg : bus.in_dest;

  fifo_sync_ft #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata (make_entry(push_dest, bus.in_data)),
    .pop   (pop),
    .rdata (head),
    .level (level),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Gate the head with valid so the demux idles at zero when nothing is
  // pending, whatever stale entry the read pointer happens to address.
  assign bus.dmx_valid = !fifo_empty;
  assign head_sel      = bus.dmx_valid && head[DEST_BIT];
  assign bus.dmx_sel   = head_sel;
  assign bus.dmx_data  = bus.dmx_valid ? head[DATA_W-1:0] : '0;

  // Only the ack of the addressed consumer can retire the head.
  assign pop = bus.dmx_valid && ((head_sel == DEST_OUT0) ? bus.ack0 : bus.ack1);

  // The pointer advances only on pushes that actually used it.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_reg <= DEST_OUT0;
    end else if (push && rr_en) begin
      rr_ptr_reg <= ~rr_ptr_reg;
    end
  end

  // One wrapping delivery counter per destination.
  for (genvar gi = 0; gi < 2; gi++) begin : gen_cnt
    logic [CNT_W-1:0] cnt_reg;

    assign deliver[gi] = pop && (head_sel == 1'(gi));

    always_ff @(posedge clk) begin
      if (rst) begin
        cnt_reg <= '0;
      end else if (deliver[gi]) begin
        cnt_reg <= cnt_reg + CNT_W'(1);
      end
    end
  end

  assign cnt0 = gen_cnt[0].cnt_reg;
  assign cnt1 = gen_cnt[1].cnt_reg;

endmodule

// File: tb/tb_dispatcher_4bits.sv
// Directed bench for dispatcher_4bits: reset state, tagged and round-robin
// destinations, full/refused pushes, wrong-ack filtering, sustained
// push+pop with counter wrap, and reset while busy.
module tb_dispatcher_4bits;

  logic       clk;
  logic       rst;
  logic       rr_en;
  logic [2:0] level;
  logic [7:0] cnt0;
  logic [7:0] cnt1;

  int total;
  int bad;

  dispatcher_4bits_if bus();

  dispatcher_4bits #(
    .DEPTH (4),
    .CNT_W (8)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .bus   (bus),
    .rr_en (rr_en),
    .level (level),
    .cnt0  (cnt0),
    .cnt1  (cnt1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s = %0h", tag, got);
    end
  endtask

  // Advance one edge; inputs change and outputs are sampled 1 ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [3:0] d, input logic dst);
    bus.in_valid = v;
    bus.in_data  = d;
    bus.in_dest  = dst;
  endtask

  int q[$];
  int exp_cnt0;
  int k;

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    rr_en = 1'b0;
    bus.ack0 = 1'b0;
    bus.ack1 = 1'b0;
    drive(1'b0, 4'h0, 1'b0);
    step();
    step();
    rst = 1'b0;
    step();

    // Reset / idle state
    chk("rst_in_ready",  32'(bus.in_ready),  32'd1);
    chk("rst_dmx_valid", 32'(bus.dmx_valid), 32'd0);
    chk("rst_dmx_data",  32'(bus.dmx_data),  32'd0);
    chk("rst_dmx_sel",   32'(bus.dmx_sel),   32'd0);
    chk("rst_cnt0",      32'(cnt0),          32'd0);
    chk("rst_cnt1",      32'(cnt1),          32'd0);
    chk("rst_level",     32'(level),         32'd0);

    // Tagged destinations with both acks held high
    bus.ack0 = 1'b1;
    bus.ack1 = 1'b1;
    drive(1'b1, 4'hA, 1'b1);
    step();
    chk("tag_a_valid", 32'(bus.dmx_valid), 32'd1);
    chk("tag_a_data",  32'(bus.dmx_data),  32'hA);
    chk("tag_a_sel",   32'(bus.dmx_sel),   32'd1);
    chk("tag_a_cnt1",  32'(cnt1),          32'd0);
    drive(1'b1, 4'h3, 1'b0);
    step();
    chk("tag_3_data",  32'(bus.dmx_data),  32'h3);
    chk("tag_3_sel",   32'(bus.dmx_sel),   32'd0);
    chk("tag_3_level", 32'(level),         32'd1);
    chk("tag_a_cnt1b", 32'(cnt1),          32'd1);
    drive(1'b0, 4'h0, 1'b0);
    step();
    chk("tag_3_cnt0",  32'(cnt0),          32'd1);
    chk("tag_empty",   32'(bus.dmx_valid), 32'd0);
    chk("tag_level0",  32'(level),         32'd0);

    // Round-robin fill, no acks; in_dest=1 must be ignored
    bus.ack0 = 1'b0;
    bus.ack1 = 1'b0;
    rr_en    = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, 4'(i), 1'b1);
      step();
      chk($sformatf("rr_level_%0d", i), 32'(level), 32'(i));
    end
    chk("full_in_ready", 32'(bus.in_ready), 32'd0);
    chk("full_head",     32'(bus.dmx_data), 32'h1);
    chk("full_sel",      32'(bus.dmx_sel),  32'd0);
    drive(1'b1, 4'h5, 1'b1);
    step();
    chk("refuse_level",  32'(level),        32'd4);
    chk("refuse_head",   32'(bus.dmx_data), 32'h1);

    // Wrong ack is ignored, right ack pops; held word accepted after
    bus.ack1 = 1'b1;
    step();
    chk("ack1_nopop_lvl",  32'(level),        32'd4);
    chk("ack1_nopop_head", 32'(bus.dmx_data), 32'h1);
    chk("ack1_nopop_cnt1", 32'(cnt1),         32'd1);
    bus.ack1 = 1'b0;
    bus.ack0 = 1'b1;
    step();
    chk("pop1_level",    32'(level),        32'd3);
    chk("pop1_in_ready", 32'(bus.in_ready), 32'd1);
    chk("pop1_head",     32'(bus.dmx_data), 32'h2);
    chk("pop1_sel",      32'(bus.dmx_sel),  32'd1);
    chk("pop1_cnt0",     32'(cnt0),         32'd2);
    bus.ack0 = 1'b0;
    step();
    chk("w5_level", 32'(level), 32'd4);
    drive(1'b0, 4'h0, 1'b0);

    // Drain: stored sels 1,0,1,0 for words 2,3,4,5
    bus.ack0 = 1'b1;
    bus.ack1 = 1'b1;
    step();
    chk("drain_3_data", 32'(bus.dmx_data), 32'h3);
    chk("drain_3_sel",  32'(bus.dmx_sel),  32'd0);
    step();
    chk("drain_4_data", 32'(bus.dmx_data), 32'h4);
    chk("drain_4_sel",  32'(bus.dmx_sel),  32'd1);
    step();
    chk("drain_5_data", 32'(bus.dmx_data), 32'h5);
    chk("drain_5_sel",  32'(bus.dmx_sel),  32'd0);
    step();
    chk("drain_empty",  32'(bus.dmx_valid), 32'd0);
    chk("drain_cnt0",   32'(cnt0),          32'd4);
    chk("drain_cnt1",   32'(cnt1),          32'd3);

    // Simultaneous push/pop at level 2, run cnt0 through its wrap
    rr_en    = 1'b0;
    bus.ack0 = 1'b0;
    bus.ack1 = 1'b0;
    drive(1'b1, 4'h6, 1'b0);
    step();
    drive(1'b1, 4'h7, 1'b0);
    step();
    chk("pp_level_start", 32'(level), 32'd2);
    q.push_back(6);
    q.push_back(7);
    exp_cnt0 = 4;
    k = 8;
    bus.ack0 = 1'b1;
    while (exp_cnt0 < 254) begin
      drive(1'b1, 4'(k), 1'b0);
      step();
      void'(q.pop_front());
      exp_cnt0++;
      q.push_back(k & 15);
      chk($sformatf("pp_level_%0d", k), 32'(level),        32'd2);
      chk($sformatf("pp_head_%0d", k),  32'(bus.dmx_data), 32'(q[0]));
      k++;
    end
    drive(1'b0, 4'h0, 1'b0);
    step();
    void'(q.pop_front());
    exp_cnt0++;
    chk("pp_tail_head",  32'(bus.dmx_data), 32'(q[0]));
    step();
    void'(q.pop_front());
    exp_cnt0++;
    chk("pp_tail_empty", 32'(bus.dmx_valid), 32'd0);
    chk("cnt0_wrap",     32'(cnt0),          32'(exp_cnt0 % 256));
    chk("cnt0_zero",     32'(cnt0),          32'd0);
    bus.ack0 = 1'b0;

    // Reset while busy with a push and a matching ack pending
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 4'(9 + i), 1'b0);
      step();
    end
    chk("busy_level", 32'(level), 32'd3);
    drive(1'b1, 4'hF, 1'b0);
    bus.ack0 = 1'b1;
    rst      = 1'b1;
    step();
    rst      = 1'b0;
    bus.ack0 = 1'b0;
    drive(1'b0, 4'h0, 1'b0);
    chk("rst2_level",     32'(level),         32'd0);
    chk("rst2_dmx_valid", 32'(bus.dmx_valid), 32'd0);
    chk("rst2_dmx_data",  32'(bus.dmx_data),  32'd0);
    chk("rst2_dmx_sel",   32'(bus.dmx_sel),   32'd0);
    chk("rst2_in_ready",  32'(bus.in_ready),  32'd1);
    chk("rst2_cnt0",      32'(cnt0),          32'd0);
    chk("rst2_cnt1",      32'(cnt1),          32'd0);
    step();
    chk("rst2_stays_empty", 32'(level), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
